// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg: shared state encoding, byte width and round-robin index math for the UART Tx arbiter.
package uart_tx_arb_pkg;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {IDLE, HDR, LOAD, SEND, WAIT} state_t;

    function automatic int rot_idx(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction
endpackage

// File: rtl/uart_rr_picker.sv
// uart_rr_picker: combinational round-robin search for the first request at or above ptr, modulo N.
module uart_rr_picker
    import uart_tx_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic             found
);
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[IDX_W'(rot_idx(int'(ptr), i, N))]) begin
                grant[IDX_W'(rot_idx(int'(ptr), i, N))] = 1'b1;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-granular sharing of one UART transmitter among N byte streams.
// Define UART_TX_ARB_HEADER_EN to prefix each packet with the header byte HEADER_BASE + grant index.
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int IDX_W = $clog2(N)
`ifdef UART_TX_ARB_HEADER_EN
    , parameter logic [BYTE_W-1:0] HEADER_BASE = 8'hA0
`endif
) (
    input  logic                ipClk,
    input  logic                ipReset,
    input  logic [N*BYTE_W-1:0] ipReqData,
    input  logic [N-1:0]        ipReqValid,
    input  logic [N-1:0]        ipReqLast,
    output logic [N-1:0]        opReqReady,
    output logic [N-1:0]        opGrant,
    output logic [BYTE_W-1:0]   opTxData,
    output logic                opTxSend,
    input  logic                ipTxBusy,
    output logic                opBusy
);
    state_t              state, state_n;
    logic [N-1:0]        grant_n, pick;
    logic                found;
    logic [IDX_W-1:0]    ptr, ptr_n, g_idx;
    logic [BYTE_W-1:0]   data_n, sel_data;
    logic                send_n, last, last_n;
    logic                sel_valid, sel_last;

    uart_rr_picker #(.N(N), .IDX_W(IDX_W)) u_picker (
        .req   (ipReqValid),
        .ptr   (ptr),
        .grant (pick),
        .found (found)
    );

    always_comb begin
        g_idx    = '0;
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (opGrant[i]) begin
                g_idx    = IDX_W'(i);
                sel_data = ipReqData[i*BYTE_W +: BYTE_W];
            end
        end
    end

    assign sel_valid  = |(ipReqValid & opGrant);
    assign sel_last   = |(ipReqLast & opGrant);
    assign opReqReady = (state == LOAD) ? opGrant : '0;
    assign opBusy     = state != IDLE;

    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            state    <= IDLE;
            ptr      <= '0;
            opGrant  <= '0;
            opTxData <= '0;
            opTxSend <= 1'b0;
            last     <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            opGrant  <= grant_n;
            opTxData <= data_n;
            opTxSend <= send_n;
            last     <= last_n;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        grant_n = opGrant;
        data_n  = opTxData;
        send_n  = opTxSend;
        last_n  = last;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_n = pick;
`ifdef UART_TX_ARB_HEADER_EN
                    state_n = HDR;
`else
                    state_n = LOAD;
`endif
                end
            end
`ifdef UART_TX_ARB_HEADER_EN
            HDR: begin
                data_n  = HEADER_BASE + BYTE_W'(g_idx);
                last_n  = 1'b0;
                send_n  = 1'b1;
                state_n = SEND;
            end
`endif
            LOAD: begin
                if (sel_valid) begin
                    data_n  = sel_data;
                    last_n  = sel_last;
                    send_n  = 1'b1;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (ipTxBusy) begin
                    send_n  = 1'b0;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                // Only release the grant once the final byte has fully left the UART.
                if (!ipTxBusy) begin
                    if (last) begin
                        grant_n = '0;
                        ptr_n   = IDX_W'(rot_idx(int'(g_idx), 1, N));
                        state_n = IDLE;
                    end else begin
                        state_n = LOAD;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed vectors against a small UART busy model and per-requester byte queues.
module tb_uart_tx_arbiter;
    localparam int N = 4;
    localparam int BUSY_CYC = 12;

    typedef struct {
        logic [3:0]  mask;
        logic [15:0] order;
        int          n;
    } vec_t;

    logic           ipClk = 1'b0;
    logic           ipReset = 1'b0;
    logic [N*8-1:0] ipReqData = '0;
    logic [N-1:0]   ipReqValid = '0;
    logic [N-1:0]   ipReqLast = '0;
    logic [N-1:0]   opReqReady, opGrant;
    logic [7:0]     opTxData;
    logic           opTxSend, opBusy;
    logic           tx_busy = 1'b0;

    int tests = 0;
    int fails = 0;
    int hs_viol = 0;
    int busy_cnt = 0;
    logic send_prev = 1'b0, busy_prev = 1'b0;
    logic [N-1:0] acc;
    logic [8:0] pq[N][$];
    logic [7:0] wire_d[$], exp_d[$];
    logic [3:0] wire_g[$], exp_g[$];
    vec_t vt[6];

    uart_tx_arbiter #(.N(N)) dut (
        .ipClk      (ipClk),
        .ipReset    (ipReset),
        .ipReqData  (ipReqData),
        .ipReqValid (ipReqValid),
        .ipReqLast  (ipReqLast),
        .opReqReady (opReqReady),
        .opGrant    (opGrant),
        .opTxData   (opTxData),
        .opTxSend   (opTxSend),
        .ipTxBusy   (tx_busy),
        .opBusy     (opBusy)
    );

    always #10 ipClk = ~ipClk;

    // Requester queues: a byte is popped after the edge that accepted it.
    always begin
        @(negedge ipClk);
        acc = opReqReady & ipReqValid;
        @(posedge ipClk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (acc[k] && pq[k].size() > 0) void'(pq[k].pop_front());
            ipReqValid[k] = pq[k].size() > 0;
            ipReqData[k*8 +: 8] = 8'h00;
            ipReqLast[k] = 1'b0;
            if (pq[k].size() > 0) begin
                ipReqData[k*8 +: 8] = pq[k][0][7:0];
                ipReqLast[k] = pq[k][0][8];
            end
        end
    end

    // UART model plus handshake monitor, evaluated away from the active edge.
    always @(negedge ipClk) begin
        if (!ipReset) begin
            tx_busy = 1'b0;
            busy_cnt = 0;
            send_prev = 1'b0;
            busy_prev = 1'b0;
        end else begin
            if (opTxSend && !send_prev && tx_busy) hs_viol++;
            if (send_prev && busy_prev && opTxSend) hs_viol++;
            if (!opTxSend && send_prev && !busy_prev) hs_viol++;
            if (tx_busy && wire_d.size() > 0 && opTxData !== wire_d[$]) hs_viol++;
            if (tx_busy) begin
                busy_cnt--;
                if (busy_cnt == 0) tx_busy = 1'b0;
            end else if (opTxSend) begin
                wire_d.push_back(opTxData);
                wire_g.push_back(opGrant);
                tx_busy = 1'b1;
                busy_cnt = BUSY_CYC;
            end
            send_prev = opTxSend;
            busy_prev = tx_busy;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input int g, input logic [7:0] d, input logic l);
        pq[g].push_back({l, d});
    endtask

    task automatic exp_byte(input int g, input logic [7:0] d);
        exp_d.push_back(d);
        exp_g.push_back(4'(1 << g));
    endtask

    task automatic exp_hdr(input int g);
`ifdef UART_TX_ARB_HEADER_EN
        exp_byte(g, 8'(8'hA0 + g));
`endif
    endtask

    function automatic bit all_done();
        for (int k = 0; k < N; k++) if (pq[k].size() != 0) return 1'b0;
        return !opBusy && !tx_busy;
    endfunction

    task automatic wait_done(input string nm);
        int c = 0;
        do begin
            @(negedge ipClk);
            c++;
        end while (!all_done() && c < 20000);
        check({nm, " done"}, 32'(all_done()), 32'd1);
    endtask

    task automatic compare(input string nm);
        check({nm, " count"}, wire_d.size(), exp_d.size());
        for (int i = 0; i < exp_d.size() && i < wire_d.size(); i++) begin
            check($sformatf("%s byte%0d", nm, i), wire_d[i], exp_d[i]);
            check($sformatf("%s grant%0d", nm, i), wire_g[i], exp_g[i]);
        end
        wire_d.delete();
        wire_g.delete();
        exp_d.delete();
        exp_g.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int g;
        int bad;
        vt[0] = '{4'b0001, 16'h0000, 1};
        vt[1] = '{4'b1111, 16'h0321, 4};
        vt[2] = '{4'b0101, 16'h0002, 2};
        vt[3] = '{4'b1000, 16'h0003, 1};
        vt[4] = '{4'b0110, 16'h0021, 2};
        vt[5] = '{4'b1001, 16'h0003, 2};

        repeat (2) @(negedge ipClk);
        #2;
        check("rst grant", opGrant, 0);
        check("rst ready", opReqReady, 0);
        check("rst send", opTxSend, 0);
        check("rst data", opTxData, 0);
        check("rst busy", opBusy, 0);
        @(negedge ipClk);
        ipReset = 1'b1;

        push(1, 8'h55, 1'b0); push(1, 8'hAA, 1'b0); push(1, 8'h0F, 1'b1);
        exp_hdr(1); exp_byte(1, 8'h55); exp_byte(1, 8'hAA); exp_byte(1, 8'h0F);
        wait_done("single");
        compare("single");
        check("single grant cleared", opGrant, 0);

        // Pointer is 2 here, so requesters 3, 0, 1 win in that order.
        push(0, 8'hC0, 1'b1); push(1, 8'hC1, 1'b1); push(3, 8'hC3, 1'b1);
        exp_hdr(3); exp_byte(3, 8'hC3);
        exp_hdr(0); exp_byte(0, 8'hC0);
        exp_hdr(1); exp_byte(1, 8'hC1);
        wait_done("simul");
        compare("simul");

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < N; k++)
                if (vt[r].mask[k]) push(k, 8'(16 * (r + 1) + k), 1'b1);
            for (int i = 0; i < vt[r].n; i++) begin
                g = int'(vt[r].order[4*i +: 4]);
                exp_hdr(g);
                exp_byte(g, 8'(16 * (r + 1) + g));
            end
            wait_done($sformatf("vec%0d", r));
            compare($sformatf("vec%0d", r));
        end

        push(2, 8'h21, 1'b0); push(2, 8'h22, 1'b1);
        c = 0;
        while (!(pq[2].size() == 0 && opTxSend) && c < 2000) begin
            @(negedge ipClk);
            c++;
        end
        check("rst reach 2nd byte", 32'(c < 2000), 32'd1);
        #2;
        ipReset = 1'b0;
        #1;
        check("midrst grant", opGrant, 0);
        check("midrst ready", opReqReady, 0);
        check("midrst send", opTxSend, 0);
        check("midrst data", opTxData, 0);
        check("midrst busy", opBusy, 0);
        for (int k = 0; k < N; k++) pq[k].delete();
        wire_d.delete(); wire_g.delete(); exp_d.delete(); exp_g.delete();
        @(negedge ipClk);
        @(negedge ipClk);
        ipReset = 1'b1;

        for (int k = 0; k < N; k++) begin
            push(k, 8'(8'h40 + 2 * k), 1'b0);
            push(k, 8'(8'h41 + 2 * k), 1'b1);
        end
        for (int k = 0; k < N; k++) begin
            exp_hdr(k);
            exp_byte(k, 8'(8'h40 + 2 * k));
            exp_byte(k, 8'(8'h41 + 2 * k));
        end
        wait_done("contend");
        compare("contend");

        // Requester 2 goes quiet mid-packet while requester 0 is waiting.
        push(2, 8'h51, 1'b0);
        exp_hdr(2); exp_byte(2, 8'h51);
        c = 0;
        while (!(pq[2].size() == 0 && opReqReady[2]) && c < 2000) begin
            @(negedge ipClk);
            c++;
        end
        check("stall reach gap", 32'(c < 2000), 32'd1);
        push(0, 8'h61, 1'b1);
        bad = 0;
        repeat (1000) begin
            @(negedge ipClk);
            if (opTxSend || opGrant != 4'b0100 || opReqReady != 4'b0100) bad++;
        end
        check("stall gap held", bad, 0);
        push(2, 8'h52, 1'b1);
        exp_byte(2, 8'h52);
        exp_hdr(0); exp_byte(0, 8'h61);
        wait_done("stall");
        compare("stall");

        push(3, 8'h12, 1'b1);
        exp_hdr(3); exp_byte(3, 8'h12);
        wait_done("hdr");
        compare("hdr");

        check("handshake violations", hs_viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
